fetch_unit: RTL and testbench

Instruction-fetch front end of the multi-cycle RV32I datapath. Holds the PC, runs the instruction-memory read handshake, captures the fetched word into the instruction register and emits a one-cycle `fetch_valid` pulse that drives the stage sequencer's `inst_resp` input. When the writeback stage reports retirement, it selects the next PC (sequential or branch/jump target) and starts the next fetch.

---
 rtl/rv32i_types.sv | 14 +
 rtl/pc_reg.sv | 37 +++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types and constants for the RV32I datapath
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_t;

    localparam rv32i_word RESET_PC_DEFAULT = 32'h0000_0060;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with sequential / aligned-target next-PC select
module pc_reg
    import rv32i_types::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Targets are word-aligned by masking; the sequential step wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = br_en ? (br_target & ~ADDR_W'(3)) : (pc_q + ADDR_W'(4));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, memory read handshake, IR
module fetch_unit
    import rv32i_types::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              inst_read,
    input  logic [31:0]       inst_rdata,
    input  logic              inst_resp,
    output logic              fetch_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    input  logic              retire,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] br_target,
    output logic [31:0]       retired_count
);

    fetch_state_t state_q, state_d;
    rv32i_word    instr_q, instr_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic [31:0]  retired_count_q, retired_count_d;
    logic         pc_load;

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        fetch_valid_d   = 1'b0;
        retired_count_d = retired_count_q;
        pc_load         = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (inst_resp) begin
                    instr_d       = inst_rdata;
                    fetch_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    pc_load         = 1'b1;
                    retired_count_d = retired_count_q + 32'd1;
                    state_d         = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            instr_q         <= '0;
            fetch_valid_q   <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            instr_q         <= instr_d;
            fetch_valid_q   <= fetch_valid_d;
            retired_count_q <= retired_count_d;
        end
    end

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .br_en     (br_en),
        .br_target (br_target),
        .pc        (pc)
    );

    // Decoded from state only so reset drops the request without a clock.
    assign inst_read     = (state_q == FETCH);
    assign inst_addr     = pc;
    assign instr         = instr_q;
    assign fetch_valid   = fetch_valid_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_addr;
    logic        inst_read;
    logic [31:0] inst_rdata = '0;
    logic        inst_resp = 1'b0;
    logic        fetch_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        retire = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] retired_count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          pulses_seen = 0;
    int          pushes = 0;
    logic [31:0] exp_pc = 32'h60;
    logic [31:0] exp_count = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .inst_addr     (inst_addr),
        .inst_read     (inst_read),
        .inst_rdata    (inst_rdata),
        .inst_resp     (inst_resp),
        .fetch_valid   (fetch_valid),
        .instr         (instr),
        .pc            (pc),
        .retire        (retire),
        .br_en         (br_en),
        .br_target     (br_target),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle fetch_valid is high must match the oldest expected capture.
    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            pulses_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fetch_valid: got pulse with instr %h pc %h, none expected", instr, pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fetch_instr", instr, e.instr);
                check("fetch_pc", pc, e.pc);
            end
        end
    end

    task automatic wait_read();
        int n = 0;
        while (inst_read !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (inst_read !== 1'b1) begin
            failures++;
            $display("FAIL read_timeout: got inst_read %b expected 1", inst_read);
        end
    endtask

    // Runs one fetch: optional spurious retires while waiting, then a response
    // held for 1+hold cycles with the given data.
    task automatic do_fetch(input int delay, input int hold, input logic [31:0] data, input bit noise);
        exp_t e;
        wait_read();
        check("fetch_addr", inst_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            inst_rdata = $urandom;
            retire     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            br_en      = 1'($urandom_range(0, 1));
            br_target  = $urandom;
            @(negedge clk);
        end
        retire     = 1'b0;
        inst_resp  = 1'b1;
        inst_rdata = data;
        e.instr    = data;
        e.pc       = exp_pc;
        exp_q.push_back(e);
        pushes++;
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            inst_rdata = $urandom;
        end
        inst_resp = 1'b0;
    endtask

    task automatic do_retire(input logic br, input logic [31:0] tgt);
        retire    = 1'b1;
        br_en     = br;
        br_target = tgt;
        @(negedge clk);
        retire    = 1'b0;
        br_en     = 1'($urandom_range(0, 1));
        br_target = $urandom;
        exp_pc    = br ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
        exp_count = exp_count + 1;
        check("retired_count", retired_count, exp_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_inst_read", {31'b0, inst_read}, 32'd0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'h60);
        check("rst_inst_addr", inst_addr, 32'h60);
        check("rst_count", retired_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("boot_inst_read", {31'b0, inst_read}, 32'd1);

        do_fetch(3, 0, 32'h0000_0013, 1'b0);
        do_retire(1'b0, 32'h0);
        check("seq_addr", inst_addr, 32'h64);
        do_fetch(1, 1, $urandom, 1'b1);
        do_retire(1'b1, 32'h0000_0103);
        check("branch_addr", inst_addr, 32'h100);
        do_fetch(0, 2, $urandom, 1'b0);
        do_retire(1'b1, 32'hFFFF_FFFF);
        do_fetch(2, 0, $urandom, 1'b1);
        do_retire(1'b0, 32'h0);
        check("wrap_addr", inst_addr, 32'h0);
        do_fetch(1, 0, $urandom, 1'b0);
        do_retire(1'b1, exp_pc);

        for (int k = 0; k < 40; k++) begin
            do_fetch($urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_retire(1'($urandom_range(0, 1)), $urandom);
        end
        do_fetch(1, 0, $urandom, 1'b0);

        // Zero-wait memory: response tied high across several retires.
        inst_resp = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            logic br;
            logic [31:0] tgt;
            br  = 1'($urandom_range(0, 1));
            tgt = $urandom;
            inst_rdata = $urandom;
            e.instr = inst_rdata;
            e.pc    = br ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
            exp_q.push_back(e);
            pushes++;
            do_retire(br, tgt);
            check("zw_addr", inst_addr, exp_pc);
            @(negedge clk);
            @(negedge clk);
        end
        inst_resp = 1'b0;

        do_retire(1'b0, 32'h0);
        check("pre_reset_read", {31'b0, inst_read}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_reset_read", {31'b0, inst_read}, 32'd0);
        check("mid_reset_pc", pc, 32'h60);
        check("mid_reset_count", retired_count, 32'd0);
        @(negedge clk);
        inst_resp  = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        inst_resp = 1'b0;
        check("reset_resp_ignored", {31'b0, fetch_valid}, 32'd0);
        rst       = 1'b1;
        exp_pc    = 32'h60;
        exp_count = 0;
        @(negedge clk);
        do_fetch(2, 0, 32'h0000_0093, 1'b0);
        do_retire(1'b0, 32'h0);
        check("post_reset_addr", inst_addr, 32'h64);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("pulse_count", pulses_seen, pushes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
